// File: rtl/clk_period_meter.sv
// clk_period_meter: measures the period and high time of a slow, divider-generated
// clock (sig_in) in clk_in cycles and checks the period against EXP_PERIOD +/- TOL.
// It asserts locked after LOCK_CNT consecutive good periods and flags a dead clock
// with timeout_err after TIMEOUT cycles without a rising edge.
//
// Interface: there is no handshake. rise_pulse, fall_pulse and meas_valid are
// single-cycle strobes. period and high_time are valid in the cycle that meas_valid
// is high, and they hold that value until the next measurement.
module clk_period_meter #(
    parameter int EXP_PERIOD = 10,
    parameter int TOL        = 1,
    parameter int LOCK_CNT   = 4,
    parameter int TIMEOUT    = 1024,
    parameter int CW         = 16
) (
    input  logic          clk_in,
    input  logic          rst_n,
    input  logic          sig_in,
    output logic [CW-1:0] period,
    output logic [CW-1:0] high_time,
    output logic          meas_valid,
    output logic          locked,
    output logic          timeout_err,
    output logic          rise_pulse,
    output logic          fall_pulse
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    // The tolerance window is one bit wider than the counter, so cnt+1 can never
    // wrap. The lower bound clamps at zero when TOL is at least EXP_PERIOD.
    localparam logic [CW:0]   LO_LIM   = (EXP_PERIOD > TOL) ? (CW+1)'(EXP_PERIOD - TOL) : '0;
    localparam logic [CW:0]   HI_LIM   = (CW+1)'(EXP_PERIOD + TOL);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_CNT);

    typedef enum logic {IDLE, MEAS} state_t;

    state_t          state, state_nx;
    logic            s1, s2, s3;
    logic            rise_ev, fall_ev, timeout_ev, in_tol;
    logic [CW-1:0]   cnt, cnt_nx, hi_cap, hi_cap_nx;
    logic [CW:0]     meas_len;
    logic [GW-1:0]   good_cnt, good_nx;
    logic [CW-1:0]   period_nx, high_time_nx;
    logic            meas_valid_nx, locked_nx, timeout_nx;

    assign rise_ev    = s2 & ~s3;
    assign fall_ev    = ~s2 & s3;
    assign meas_len   = {1'b0, cnt} + (CW+1)'(1);
    assign in_tol     = (meas_len >= LO_LIM) && (meas_len <= HI_LIM);
    assign timeout_ev = (cnt == CNT_MAX) && !rise_ev;

    // Two-flop synchroniser for the asynchronous sig_in, plus a history flop for edge detection
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // FSM state register
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state and next-value logic; a rise takes priority over a timeout in the same cycle
    always_comb begin
        state_nx      = state;
        cnt_nx        = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
        hi_cap_nx     = hi_cap;
        period_nx     = period;
        high_time_nx  = high_time;
        meas_valid_nx = 1'b0;
        locked_nx     = locked;
        timeout_nx    = timeout_err;
        good_nx       = good_cnt;
        if (fall_ev) hi_cap_nx = meas_len[CW-1:0];
        if (rise_ev) begin
            cnt_nx     = '0;
            timeout_nx = 1'b0;
            state_nx   = MEAS;
            if (state == MEAS) begin
                period_nx     = meas_len[CW-1:0];
                high_time_nx  = hi_cap;
                meas_valid_nx = 1'b1;
                if (in_tol) begin
                    good_nx   = (good_cnt == GOOD_MAX) ? good_cnt : good_cnt + GW'(1);
                    locked_nx = (good_nx == GOOD_MAX);
                end else begin
                    good_nx   = '0;
                    locked_nx = 1'b0;
                end
            end
        end else if (timeout_ev) begin
            timeout_nx = 1'b1;
            locked_nx  = 1'b0;
            good_nx    = '0;
            state_nx   = IDLE;
        end
    end

    // Counter, capture and registered outputs
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            hi_cap      <= '0;
            good_cnt    <= '0;
            period      <= '0;
            high_time   <= '0;
            meas_valid  <= 1'b0;
            locked      <= 1'b0;
            timeout_err <= 1'b0;
            rise_pulse  <= 1'b0;
            fall_pulse  <= 1'b0;
        end else begin
            cnt         <= cnt_nx;
            hi_cap      <= hi_cap_nx;
            good_cnt    <= good_nx;
            period      <= period_nx;
            high_time   <= high_time_nx;
            meas_valid  <= meas_valid_nx;
            locked      <= locked_nx;
            timeout_err <= timeout_nx;
            rise_pulse  <= rise_ev;
            fall_pulse  <= fall_ev;
        end
    end

endmodule

// File: tb/tb_clk_period_meter.sv
// Bench for clk_period_meter. The driver shapes sig_in as (high, low) cycle pairs.
// A period-level model predicts the outcome of every rising edge and pushes it to
// exp_q. A monitor pops exp_q on each rise_pulse and checks timeout_err, locked and
// the reset values on every cycle.
module tb_clk_period_meter;

    localparam int EXP  = 10;
    localparam int TOL  = 1;
    localparam int LOCK = 4;
    localparam int TMO  = 64;
    localparam int CW   = 16;
    localparam int EW   = 2 + 2*CW;

    logic          clk_in = 1'b0;
    logic          rst_n  = 1'b0;
    logic          sig_in = 1'b0;
    logic [CW-1:0] period, high_time;
    logic          meas_valid, locked, timeout_err, rise_pulse, fall_pulse;

    int checks = 0;
    int passed = 0;

    // Model state
    logic [EW-1:0] exp_q[$];
    bit  m_active = 1'b0;
    int  m_good = 0, m_last_p = 0, m_last_h = 0;
    int  prev_h = 0, prev_l = 0;
    int  falls_sent = 0, falls_seen = 0;
    int  since = 0;

    // Clock generation
    always #5 clk_in = ~clk_in;

    clk_period_meter #(
        .EXP_PERIOD(EXP), .TOL(TOL), .LOCK_CNT(LOCK), .TIMEOUT(TMO), .CW(CW)
    ) dut (
        .clk_in(clk_in), .rst_n(rst_n), .sig_in(sig_in),
        .period(period), .high_time(high_time), .meas_valid(meas_valid),
        .locked(locked), .timeout_err(timeout_err),
        .rise_pulse(rise_pulse), .fall_pulse(fall_pulse)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act === exp_v) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    endtask

    // Predict what the DUT reports for the rise being issued now. The period that
    // ends at this rise is the previous high+low.
    task automatic push_rise();
        logic meas;
        int   p;
        meas = 1'b0;
        if (!m_active) begin
            m_active = 1'b1;
        end else begin
            p = prev_h + prev_l;
            if (p > TMO) begin
                m_good = 0;
            end else begin
                meas     = 1'b1;
                m_last_p = p;
                m_last_h = prev_h;
                if (p >= EXP - TOL && p <= EXP + TOL) m_good = (m_good < LOCK) ? m_good + 1 : LOCK;
                else m_good = 0;
            end
        end
        exp_q.push_back({meas, (m_good == LOCK), CW'(m_last_p), CW'(m_last_h)});
    endtask

    task automatic send(input int h, input int l);
        push_rise();
        sig_in = 1'b1;
        repeat (h) @(negedge clk_in);
        sig_in = 1'b0;
        falls_sent++;
        repeat (l) @(negedge clk_in);
        prev_h = h;
        prev_l = l;
    endtask

    task automatic reset_mid_high();
        push_rise();
        sig_in = 1'b1;
        repeat (4) @(negedge clk_in);
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs",
                 64'({period, high_time, meas_valid, locked, timeout_err, rise_pulse, fall_pulse}), 64'(0));
        sig_in = 1'b0;
        repeat (3) @(negedge clk_in);
        #1 rst_n = 1'b1;
        m_active = 1'b0;
        m_good   = 0;
        m_last_p = 0;
        m_last_h = 0;
        repeat (3) @(negedge clk_in);
    endtask

    // Monitor: samples on the falling edge, away from the active edge
    always @(negedge clk_in) begin
        logic [EW-1:0] e;
        if (!rst_n) begin
            since = 0;
            check("reset_outputs",
                  64'({period, high_time, meas_valid, locked, timeout_err, rise_pulse, fall_pulse}), 64'(0));
        end else begin
            if (fall_pulse) falls_seen++;
            check("rise_fall_excl", 64'(rise_pulse & fall_pulse), 64'(0));
            if (rise_pulse) begin
                since = 0;
                check("rise_expected", 64'(exp_q.size() > 0), 64'(1));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("meas_valid", 64'(meas_valid), 64'(e[EW-1]));
                    check("locked", 64'(locked), 64'(e[EW-2]));
                    check("period", 64'(period), 64'(e[2*CW-1:CW]));
                    check("high_time", 64'(high_time), 64'(e[CW-1:0]));
                end
                check("timeout_clear", 64'(timeout_err), 64'(0));
            end else begin
                since++;
                check("meas_without_rise", 64'(meas_valid), 64'(0));
                check("timeout_err", 64'(timeout_err), 64'(since >= TMO));
                if (since >= TMO) check("locked_timeout", 64'(locked), 64'(0));
            end
        end
    end

    // Watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        int h, l, p;
        rst_n  = 1'b0;
        sig_in = 1'b0;
        repeat (3) @(negedge clk_in);
        #1 rst_n = 1'b1;
        repeat (4) @(negedge clk_in);

        // 5/5 square wave: lock on the 5th rise
        repeat (6) send(5, 5);
        // 3/7 duty, then a 12-cycle period breaks lock
        repeat (5) send(3, 7);
        repeat (2) send(6, 6);
        // relock, tolerate 9, drop on 13, relock
        repeat (5) send(5, 5);
        send(4, 5);
        send(5, 5);
        send(6, 7);
        repeat (5) send(5, 5);
        // dead clock: timeout, then resume
        send(5, 80);
        repeat (3) send(5, 5);
        // rise exactly on the last count: period 64, no timeout
        send(5, 59);
        repeat (2) send(5, 5);

        // randomized periods around the target, with occasional long gaps
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                h = $urandom_range(2, 20);
                l = $urandom_range(45, 80);
            end else begin
                p = $urandom_range(EXP - 3, EXP + 3);
                h = $urandom_range(1, p - 1);
                l = p - h;
            end
            send(h, l);
        end

        // lock, then reset in the middle of a high phase
        repeat (6) send(5, 5);
        reset_mid_high();
        repeat (6) send(5, 5);

        repeat (8) @(negedge clk_in);
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        check("fall_count", 64'(falls_seen), 64'(falls_sent));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/clk_period_meter.md
Name: clk_period_meter

Overview:
- Receive-side companion to the team's clock divider. It samples a slow, divider-generated clock (mic/PDM bit clock, pixel strobe) in the fast clk_in domain.
- Measures the period and high time of that clock in clk_in cycles and checks the period against an expected divide ratio.
- Asserts a lock flag after consecutive good periods and flags a dead clock by timeout.
- Sits beside each divider output feeding the mic array, as a bring-up and health monitor.

Parameters:
- EXP_PERIOD, 10, expected period of sig_in in clk_in cycles (the divider SCALER).
- TOL, 1, allowed absolute deviation of a measured period from EXP_PERIOD.
- LOCK_CNT, 4, consecutive in-tolerance periods required to assert locked.
- TIMEOUT, 1024, clk_in cycles without a rise event before timeout_err; must be <= 2^CW-1.
- CW, 16, width of the counter and of the measurement outputs.

Ports:
- clk_in  input  1  fast sampling clock
- rst_n  input  1  asynchronous active-low reset
- sig_in  input  1  slow clock under measurement; asynchronous to clk_in
- period  output  CW  last measured period in clk_in cycles
- high_time  output  CW  last measured high time in clk_in cycles
- meas_valid  output  1  one-cycle pulse; period/high_time updated this cycle
- locked  output  1  LOCK_CNT consecutive in-tolerance periods seen
- timeout_err  output  1  no rise event for TIMEOUT cycles; sticky until the next rise
- rise_pulse  output  1  one-cycle pulse per detected rising edge of sig_in
- fall_pulse  output  1  one-cycle pulse per detected falling edge of sig_in

Behaviour:
- Reset: reset rst_n, asynchronous, active-low; clock clk_in. While rst_n=0, all outputs are 0, cnt=0, good_cnt=0, hi_cap=0, state=IDLE.
- Synchroniser: 2-FF chain s1, s2 plus history flop s3.
  - Internal rise event: s2 & ~s3. Internal fall event: ~s2 & s3.
  - All outputs are registered and update on the edge at which the event is present.
  - Latency: sig_in first sampled high at edge k gives rise_pulse high during the cycle after edge k+2. Falling edge behaves the same way.
- Counter cnt (CW bits):
  - On a rise event: cnt <= 0.
  - Otherwise: cnt <= cnt+1, saturating at TIMEOUT-1.
- High-time capture: on a fall event, hi_cap <= cnt+1.
- States:
  - IDLE: waiting for the first rise. A rise event moves to MEAS and clears timeout_err. No meas_valid is produced.
  - MEAS: each rise event loads period <= cnt+1 and high_time <= hi_cap, and pulses meas_valid.
  - Example: a 5-high/5-low sig_in gives period=10, high_time=5.
- Tolerance check (on each MEAS rise): good when |(cnt+1) - EXP_PERIOD| <= TOL. Width-safe: compare against EXP_PERIOD-TOL and EXP_PERIOD+TOL.
  - Good: good_cnt <= min(good_cnt+1, LOCK_CNT); locked <= 1 when the new good_cnt equals LOCK_CNT, in the same cycle as meas_valid.
  - Bad: good_cnt <= 0 and locked <= 0 in the same cycle as meas_valid.
- Timeout (IDLE or MEAS): when cnt==TIMEOUT-1 and there is no rise event:
  - timeout_err <= 1, locked <= 0, good_cnt <= 0, state <= IDLE.
  - cnt holds at TIMEOUT-1 after that.
- Simultaneous events:
  - Rise and timeout condition in the same cycle: the rise wins. The period is measured as TIMEOUT (normally bad) and no timeout_err is raised.
  - Rise and fall cannot coincide, because s2 has one value per cycle.
- period and high_time hold their last values between measurements and through a timeout.
- Reset mid-measurement: every output clears immediately. The first rise after reset is IDLE→MEAS only, with no meas_valid.

Test Plan:
1. EXP=10, TOL=1, LOCK=4; sig_in 5 high/5 low after reset -> no meas_valid on the 1st rise_pulse. meas_valid on every later rise_pulse with period=10, high_time=5. locked rises with the 4th meas_valid (5th rise).
2. sig_in 3 high/7 low -> period=10, high_time=3, locked after 4 valid measurements. Then 6/6 -> period=12, locked drops with that meas_valid.
3. Locked at period 10, then one 9-cycle period -> locked stays 1. Then one 13-cycle period -> locked=0 in the same cycle as meas_valid, followed by 4 good periods -> relock.
4. TIMEOUT=64; sig_in held low after a rise -> timeout_err=1 visible 64 cycles after that rise_pulse, locked=0, period unchanged. Resume -> 1st rise_pulse clears timeout_err without meas_valid; 2nd rise gives meas_valid with period=10.
5. Rise event arriving on exactly the cycle cnt==TIMEOUT-1 -> meas_valid with period=64, timeout_err stays 0, locked=0.
6. Assert rst_n low mid-high-phase while locked -> all outputs 0 without a clock edge. After release, the first rise produces no meas_valid; measurement resumes on the second rise.
